// File: rtl/meter_decrementer.sv
// Seconds countdown meter: 1 s prescaler, saturating add/decrement of BCOUNT,
// and a mode FSM that flashes the display while the count is low or expired.
module meter_decrementer #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        add10,
  input  logic        add180,
  input  logic        add200,
  input  logic        add550,
  input  logic        rst10,
  input  logic        rst205,
  output logic [13:0] BCOUNT,
  output logic        blank,
  output logic        expired
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_DIV / 2 - 1);

  typedef enum logic [1:0] {
    MODE_ZERO,
    MODE_LOW,
    MODE_NORMAL
  } mode_e;

  logic [PW-1:0] presc_q, presc_d;
  logic [13:0]   count_q, count_d;
  mode_e         mode_q, mode_d;
  logic          blank_q, blank_d;

  logic          tick, half_tick, load;
  logic [14:0]   add_sum, count_sum;

  always_comb begin
    tick      = (presc_q == PRESC_MAX);
    half_tick = (presc_q == PRESC_HALF);
    load      = rst10 | rst205;

    add_sum = (add10  ? 15'd10  : '0) + (add180 ? 15'd180 : '0)
            + (add200 ? 15'd200 : '0) + (add550 ? 15'd550 : '0);
    // decrement only when nonzero, so the 15-bit sum can never underflow
    count_sum = {1'b0, count_q} - 15'(tick && (count_q != '0)) + add_sum;

    if (load) begin
      count_d = rst205 ? 14'd205 : 14'd10;
      presc_d = '0;
    end else begin
      count_d = (count_sum > 15'd9999) ? 14'd9999 : count_sum[13:0];
      presc_d = tick ? '0 : presc_q + PW'(1);
    end

    if (count_d == '0)          mode_d = MODE_ZERO;
    else if (count_d < 14'd200) mode_d = MODE_LOW;
    else                        mode_d = MODE_NORMAL;

    // a mode change or a load restarts the flash phase with digits on
    blank_d = 1'b0;
    if (!load && (mode_d == mode_q)) begin
      case (mode_q)
        MODE_LOW:  blank_d = blank_q ^ tick;
        MODE_ZERO: blank_d = blank_q ^ (tick | half_tick);
        default:   blank_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      count_q <= '0;
      mode_q  <= MODE_ZERO;
      blank_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      blank_q <= blank_d;
    end
  end

  assign BCOUNT  = count_q;
  assign blank   = blank_q;
  assign expired = (count_q == '0);

endmodule

// File: tb/tb_meter_decrementer.sv
// Randomized and directed bench for meter_decrementer; a reference model
// predicts every cycle's outputs into a queue consumed by a separate monitor.
module tb_meter_decrementer;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        reset, add10, add180, add200, add550, rst10, rst205;
  logic [13:0] BCOUNT;
  logic        blank, expired;

  meter_decrementer #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset),
    .add10(add10), .add180(add180), .add200(add200), .add550(add550),
    .rst10(rst10), .rst205(rst205),
    .BCOUNT(BCOUNT), .blank(blank), .expired(expired)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int blk;
    int exp;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: seconds, cycle within the second, flash events since
  // the current mode (or load) began.
  int m_cnt = 0, m_presc = 0, m_mode = 0, m_events = 0, m_blank = 0;

  function automatic int mode_of(input int c);
    if (c == 0) return 0;
    if (c < 200) return 1;
    return 2;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model(input bit r, a1, a2, a3, a4, l10, l205);
    bit tk, hf, ld;
    int nc, nm;
    if (r) begin
      m_cnt = 0; m_presc = 0; m_mode = 0; m_events = 0; m_blank = 0;
      return;
    end
    tk = (m_presc == TD - 1);
    hf = (m_presc == TD / 2 - 1);
    ld = l10 || l205;
    if (ld) begin
      nc = l205 ? 205 : 10;
      m_presc = 0;
    end else begin
      nc = m_cnt + 10 * a1 + 180 * a2 + 200 * a3 + 550 * a4;
      if (tk && m_cnt > 0) nc = nc - 1;
      if (nc > 9999) nc = 9999;
      m_presc = (m_presc + 1) % TD;
    end
    nm = mode_of(nc);
    if (ld || nm != m_mode) m_events = 0;
    else if (nm == 1 && tk) m_events++;
    else if (nm == 0 && (tk || hf)) m_events++;
    m_blank = (nm == 2) ? 0 : m_events % 2;
    m_mode = nm;
    m_cnt = nc;
  endtask

  task automatic step(input bit r, a1, a2, a3, a4, l10, l205);
    exp_t e;
    @(negedge clk);
    reset = r; add10 = a1; add180 = a2; add200 = a3; add550 = a4;
    rst10 = l10; rst205 = l205;
    model(r, a1, a2, a3, a4, l10, l205);
    e.cnt = m_cnt; e.blk = m_blank; e.exp = (m_cnt == 0);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic run_until_cnt(input int target, input int limit);
    int n = 0;
    while (m_cnt != target && n < limit) begin
      idle();
      n++;
    end
    chk("wait_for_count", m_cnt, target);
  endtask

  // Monitor: outputs are valid every cycle once stimulus has started.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_bcount",  int'(BCOUNT),  e.cnt);
        chk("sb_blank",   int'(blank),   e.blk);
        chk("sb_expired", int'(expired), e.exp);
      end
    end
  end

  initial begin
    {reset, add10, add180, add200, add550, rst10, rst205} = '0;

    // reset state
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("reset_bcount", int'(BCOUNT), 0);
    chk("reset_expired", int'(expired), 1);
    chk("reset_blank", int'(blank), 0);

    // add200 -> NORMAL, then into LOW with flash
    step(0, 0, 0, 1, 0, 0, 0);
    chk("add200_bcount", int'(BCOUNT), 200);
    chk("add200_blank", int'(blank), 0);
    run_until_cnt(199, 20);
    chk("low_entry_bcount", int'(BCOUNT), 199);
    chk("low_entry_blank", int'(blank), 0);
    run_until_cnt(198, 20);
    chk("low_second_blank", int'(blank), 1);

    // saturation near 9999
    step(1, 0, 0, 0, 0, 0, 0);
    repeat (19) step(0, 0, 0, 0, 1, 0, 0);
    chk("sat_bcount", int'(BCOUNT), 9999);
    run_until_cnt(9990, 100);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("add550_sat", int'(BCOUNT), 9999);
    while (m_presc != TD - 1) idle();
    step(0, 1, 0, 0, 0, 0, 0);
    chk("add10_tick_sat", int'(BCOUNT), 9999);

    // rst10 countdown to zero and hold
    step(0, 0, 0, 0, 0, 1, 0);
    chk("rst10_load", int'(BCOUNT), 10);
    run_until_cnt(0, 100);
    chk("expired_at_zero", int'(expired), 1);
    repeat (4 * TD) idle();
    chk("zero_hold", int'(BCOUNT), 0);

    // simultaneous adds; load beats add
    step(0, 1, 1, 0, 0, 0, 0);
    chk("add10_add180", int'(BCOUNT), 190);
    step(0, 0, 0, 0, 1, 1, 0);
    chk("rst10_over_add550", int'(BCOUNT), 10);
    step(0, 0, 0, 0, 0, 1, 1);
    chk("rst205_over_rst10", int'(BCOUNT), 205);
    repeat (3 * TD) idle();

    // reset mid-countdown beats add200
    run_until_cnt(150, 400);
    step(1, 0, 0, 1, 0, 0, 0);
    chk("reset_mid_bcount", int'(BCOUNT), 0);
    chk("reset_mid_blank", int'(blank), 0);
    chk("reset_mid_expired", int'(expired), 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, a1, a2, a3, a4, l1, l2;
      r  = ($urandom_range(0, 499) == 0);
      a1 = ($urandom_range(0, 29) == 0);
      a2 = ($urandom_range(0, 39) == 0);
      a3 = ($urandom_range(0, 39) == 0);
      a4 = ($urandom_range(0, 59) == 0);
      l1 = ($urandom_range(0, 149) == 0);
      l2 = ($urandom_range(0, 149) == 0);
      step(r, a1, a2, a3, a4, l1, l2);
    end

    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/meter_decrementer.md
METER_DECREMENTER -- requirements
Module: meter_decrementer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000000, meaning clk cycles per one-second tick (minimum 4, even).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports add10, add180, add200, add550  input  1 each  single-cycle pulses adding 10/180/200/550 seconds.
REQ-005 SHALL have ports rst10, rst205  input  1 each  single-cycle pulses loading 10/205 seconds.
REQ-006 SHALL have port BCOUNT  output  14  remaining seconds, binary, range 0..9999.
REQ-007 SHALL have port blank  output  1  1 = display digits off (flash phase).
REQ-008 SHALL have port expired  output  1  1 when BCOUNT == 0.

Function
REQ-009 SHALL run a prescaler 0..TICK_DIV-1, wrapping to 0; tick is asserted for the single cycle in which the prescaler equals TICK_DIV-1.
REQ-010 SHALL, on tick with BCOUNT > 0, decrement BCOUNT by 1; SHALL hold at 0 (no wrap to 16383).
REQ-011 SHALL sum all add pulses asserted in the same cycle (e.g. add10+add550 = 560).
REQ-012 SHALL compute next BCOUNT = min(9999, BCOUNT - dec + addsum), where dec = tick and (BCOUNT > 0); intermediate math at least 15 bits, no overflow.
REQ-013 SHALL give rst10/rst205 priority over adds and tick; if both are asserted, rst205 wins; the load also clears the prescaler to 0 and restarts the flash phase.
REQ-014 SHALL update BCOUNT one cycle after the pulse/tick (registered, latency 1).
REQ-015 SHALL keep a mode FSM, registered and updated from next BCOUNT: ZERO (count 0), LOW (1..199), NORMAL (200..9999).
REQ-016 SHALL drive blank = 0 in NORMAL.
REQ-017 SHALL, in LOW, toggle blank on every tick (1 s on, 1 s off); blank = 0 in the first second after entering LOW.
REQ-018 SHALL, in ZERO, toggle blank at each tick and at prescaler == TICK_DIV/2-1 (0.5 s on, 0.5 s off); blank = 0 on entry to ZERO.
REQ-019 SHALL, on any mode transition, force blank = 0 in the same cycle BCOUNT updates.
REQ-020 SHALL drive expired combinationally as (BCOUNT == 0).
REQ-021 SHALL ignore add pulses longer than one cycle as repeated pulses (one add per asserted cycle); debouncing is upstream.

Reset
REQ-022 SHALL, on reset, set BCOUNT = 0, prescaler = 0, mode = ZERO, blank = 0; expired = 1 follows.
REQ-023 SHALL give reset priority over all other inputs, including mid-countdown and simultaneous pulses.

Verification (TICK_DIV = 4)
REQ-024 SHALL cover: reset, then add200 -> BCOUNT = 200 next cycle, mode NORMAL, blank 0; after 1 tick -> 199, mode LOW, blank 0; next tick -> 198, blank 1.
REQ-025 SHALL cover: BCOUNT = 9990, add550 -> 9999; add10 with tick same cycle at 9999 -> 9999 (saturate).
REQ-026 SHALL cover: rst10 -> 10; run 10 ticks -> 0, expired 1; further ticks -> stays 0; blank toggles every 2 cycles in ZERO.
REQ-027 SHALL cover: add10 and add180 same cycle from 0 -> 190; rst10 and add550 same cycle -> 10 and prescaler = 0.
REQ-028 SHALL cover: reset asserted mid-countdown at BCOUNT = 150 with add200 pulse -> BCOUNT 0, blank 0, expired 1.
